// File: rtl/fig_arbiter.sv
// fig_arbiter: round-robin arbiter sharing one figure draw engine between
// NUM_SRC point sources. The winning source's fields are latched at grant time
// and the downstream ack is relayed back to that source only.
// Optional build macro FIG_ARB_BURST_EN: lets the last winner keep the grant for
// up to BURST_LEN consecutive transfers before rotation is forced.
module fig_arbiter #(
    parameter int unsigned NUM_SRC   = 4,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_SRC*8-1:0] src_x_i,
    input  logic [NUM_SRC*9-1:0] src_y_i,
    input  logic [NUM_SRC*8-1:0] src_h_i,
    input  logic [NUM_SRC*8-1:0] src_s_i,
    input  logic [NUM_SRC*8-1:0] src_v_i,
    input  logic [NUM_SRC-1:0]   src_req_i,
    output logic [NUM_SRC-1:0]   src_ack_o,
    output logic [7:0]           fig_x_o,
    output logic [8:0]           fig_y_o,
    output logic [7:0]           fig_h_o,
    output logic [7:0]           fig_s_o,
    output logic [7:0]           fig_v_o,
    output logic                 fig_req_o,
    input  logic                 fig_ack_i,
    output logic [NUM_SRC-1:0]   grant_o
);

    localparam int unsigned IDX_W = $clog2(NUM_SRC);

    // Reject out-of-range configurations at elaboration.
    if (NUM_SRC < 2 || NUM_SRC > 16) begin : g_bad_num_src
        $error("fig_arbiter: NUM_SRC out of range");
    end
    if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_burst_len
        $error("fig_arbiter: BURST_LEN out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   last_q;
    logic [NUM_SRC-1:0] grant_q;
    logic [NUM_SRC-1:0] src_ack_q;
    logic               fig_req_q;
    logic [7:0]         fig_x_q;
    logic [8:0]         fig_y_q;
    logic [7:0]         fig_h_q;
    logic [7:0]         fig_s_q;
    logic [7:0]         fig_v_q;

    logic [IDX_W-1:0]   rr_win_c;
    logic [IDX_W-1:0]   rr_idx_c;
    logic               rr_hit_c;
    logic [IDX_W-1:0]   win_c;

    // Round-robin search: first requester from last+1 upward, wrapping, ending at last.
    always_comb begin
        rr_win_c = last_q;
        rr_idx_c = last_q;
        rr_hit_c = 1'b0;
        for (int i = 1; i <= int'(NUM_SRC); i++) begin
            rr_idx_c = IDX_W'((int'(last_q) + i) % int'(NUM_SRC));
            if (!rr_hit_c && src_req_i[rr_idx_c]) begin
                rr_hit_c = 1'b1;
                rr_win_c = rr_idx_c;
            end
        end
    end

`ifdef FIG_ARB_BURST_EN
    logic [7:0] burst_cnt_q;
    logic [7:0] burst_cnt_d;
    logic       granted_q;  // last_q names a real previous winner, not the reset value

    // Keep the grant on last while under the burst limit, else rotate and restart the count.
    always_comb begin
        if (granted_q && src_req_i[last_q] && (burst_cnt_q < 8'(BURST_LEN - 1))) begin
            win_c       = last_q;
            burst_cnt_d = burst_cnt_q + 8'd1;
        end else begin
            win_c       = rr_win_c;
            burst_cnt_d = 8'd0;
        end
    end

    // Burst bookkeeping, updated only when a grant is issued.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            burst_cnt_q <= 8'd0;
            granted_q   <= 1'b0;
        end else if (state_q == ST_IDLE && (|src_req_i)) begin
            burst_cnt_q <= burst_cnt_d;
            granted_q   <= 1'b1;
        end
    end
`else
    assign win_c = rr_win_c;
`endif

    // Arbiter FSM: grant in IDLE, hold in WAIT until ack, one RELEASE cycle for the source to drop req.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            last_q    <= IDX_W'(NUM_SRC - 1);
            grant_q   <= '0;
            src_ack_q <= '0;
            fig_req_q <= 1'b0;
            fig_x_q   <= 8'd0;
            fig_y_q   <= 9'd0;
            fig_h_q   <= 8'd0;
            fig_s_q   <= 8'd0;
            fig_v_q   <= 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    src_ack_q <= '0;
                    if (|src_req_i) begin
                        fig_x_q   <= src_x_i[8*win_c +: 8];
                        fig_y_q   <= src_y_i[9*win_c +: 9];
                        fig_h_q   <= src_h_i[8*win_c +: 8];
                        fig_s_q   <= src_s_i[8*win_c +: 8];
                        fig_v_q   <= src_v_i[8*win_c +: 8];
                        fig_req_q <= 1'b1;
                        grant_q   <= NUM_SRC'(1) << win_c;
                        last_q    <= win_c;
                        state_q   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (fig_ack_i) begin
                        fig_req_q <= 1'b0;
                        src_ack_q <= grant_q;
                        grant_q   <= '0;
                        state_q   <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    src_ack_q <= '0;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign src_ack_o = src_ack_q;
    assign grant_o   = grant_q;
    assign fig_req_o = fig_req_q;
    assign fig_x_o   = fig_x_q;
    assign fig_y_o   = fig_y_q;
    assign fig_h_o   = fig_h_q;
    assign fig_s_o   = fig_s_q;
    assign fig_v_o   = fig_v_q;

endmodule

// File: tb/tb_fig_arbiter.sv
// Directed bench for fig_arbiter in its default (round-robin only) build.
module tb_fig_arbiter;

    localparam int unsigned NUM_SRC = 4;

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic [NUM_SRC*8-1:0] src_x;
    logic [NUM_SRC*9-1:0] src_y;
    logic [NUM_SRC*8-1:0] src_h;
    logic [NUM_SRC*8-1:0] src_s;
    logic [NUM_SRC*8-1:0] src_v;
    logic [NUM_SRC-1:0]   src_req;
    logic [NUM_SRC-1:0]   src_ack;
    logic [7:0]           fig_x;
    logic [8:0]           fig_y;
    logic [7:0]           fig_h;
    logic [7:0]           fig_s;
    logic [7:0]           fig_v;
    logic                 fig_req;
    logic                 fig_ack;
    logic [NUM_SRC-1:0]   grant;

    int n_vec  = 0;
    int n_miss = 0;

    fig_arbiter #(.NUM_SRC(NUM_SRC), .BURST_LEN(2)) u_dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .src_x_i   (src_x),
        .src_y_i   (src_y),
        .src_h_i   (src_h),
        .src_s_i   (src_s),
        .src_v_i   (src_v),
        .src_req_i (src_req),
        .src_ack_o (src_ack),
        .fig_x_o   (fig_x),
        .fig_y_o   (fig_y),
        .fig_h_o   (fig_h),
        .fig_s_o   (fig_s),
        .fig_v_o   (fig_v),
        .fig_req_o (fig_req),
        .fig_ack_i (fig_ack),
        .grant_o   (grant)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one rising edge and settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        reset_n = 1'b0;
        fig_ack = 1'b0;
        src_req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            src_x[8*k +: 8] = 8'(8'h10 + k);
            src_y[9*k +: 9] = 9'(9'h020 + k);
            src_h[8*k +: 8] = 8'(8'h40 + k);
            src_s[8*k +: 8] = 8'(8'h50 + k);
            src_v[8*k +: 8] = 8'(8'h60 + k);
        end

        // Reset for two edges.
        tick();
        tick();
        check_eq("rst_grant",   32'(grant),   32'h0);
        check_eq("rst_fig_req", 32'(fig_req), 32'h0);
        check_eq("rst_src_ack", 32'(src_ack), 32'h0);
        check_eq("rst_fig_x",   32'(fig_x),   32'h0);
        check_eq("rst_fig_y",   32'(fig_y),   32'h0);

        // First sampling edge after reset: source 0 wins.
        reset_n = 1'b1;
        tick();
        check_eq("first_grant",   32'(grant),   32'h1);
        check_eq("first_fig_x",   32'(fig_x),   32'h10);
        check_eq("first_fig_y",   32'(fig_y),   32'h020);
        check_eq("first_fig_req", 32'(fig_req), 32'h1);

        // Rotation with all sources requesting; ack two cycles after each request.
        for (int n = 0; n < 5; n++) begin
            check_eq($sformatf("rot%0d_grant", n), 32'(grant), 32'(4'b0001 << exp_order[n]));
            check_eq($sformatf("rot%0d_fig_x", n), 32'(fig_x), 32'(8'h10 + exp_order[n]));
            check_eq($sformatf("rot%0d_fig_h", n), 32'(fig_h), 32'(8'h40 + exp_order[n]));
            tick();
            check_eq($sformatf("rot%0d_hold_req", n), 32'(fig_req), 32'h1);
            fig_ack = 1'b1;
            tick();
            fig_ack = 1'b0;
            check_eq($sformatf("rot%0d_src_ack", n), 32'(src_ack), 32'(4'b0001 << exp_order[n]));
            check_eq($sformatf("rot%0d_req_low", n), 32'(fig_req), 32'h0);
            check_eq($sformatf("rot%0d_grant0", n),  32'(grant),   32'h0);
            if (n == 4) src_req = 4'b1010;
            tick();
            check_eq($sformatf("rot%0d_ack_gone", n), 32'(src_ack), 32'h0);
            if (n != 4) tick();
        end

        // Ack routing: last winner is 0, src1 and src3 request, src1 granted.
        src_x[15:8] = 8'h33;
        tick();
        check_eq("route_grant", 32'(grant), 32'h2);
        check_eq("route_fig_x", 32'(fig_x), 32'h33);

        // Field stability: changing src1's X during WAIT must not reach the output.
        src_x[15:8] = 8'h44;
        tick();
        check_eq("stable_fig_x_a", 32'(fig_x), 32'h33);
        tick();
        check_eq("stable_fig_x_b", 32'(fig_x), 32'h33);

        fig_ack = 1'b1;
        tick();
        check_eq("route_src_ack", 32'(src_ack), 32'h2);
        check_eq("route_req_low", 32'(fig_req), 32'h0);
        check_eq("route_grant0",  32'(grant),   32'h0);
        // Source 1 drops its request; ack stays high into RELEASE and must be ignored.
        src_req = 4'b1000;
        tick();
        fig_ack = 1'b0;
        check_eq("release_ack_ignored", 32'(src_ack), 32'h0);
        check_eq("release_req_low",     32'(fig_req), 32'h0);
        tick();
        check_eq("route_next_grant", 32'(grant), 32'h8);
        check_eq("route_next_x",     32'(fig_x), 32'h13);

        // Complete source 3 and go idle.
        fig_ack = 1'b1;
        tick();
        fig_ack = 1'b0;
        src_req = 4'b0000;
        check_eq("src3_ack", 32'(src_ack), 32'h8);
        tick();
        tick();

        // Stray ack in IDLE with no requests.
        fig_ack = 1'b1;
        tick();
        fig_ack = 1'b0;
        check_eq("stray_src_ack", 32'(src_ack), 32'h0);
        check_eq("stray_grant",   32'(grant),   32'h0);
        check_eq("stray_fig_req", 32'(fig_req), 32'h0);
        // Still in IDLE: a new request is granted on the very next edge.
        src_req = 4'b0100;
        tick();
        check_eq("stray_then_grant", 32'(grant),   32'h4);
        check_eq("stray_then_req",   32'(fig_req), 32'h1);

        // Reset mid-transfer while source 2 is in WAIT, with an ack arriving simultaneously.
        src_req = 4'b1111;
        reset_n = 1'b0;
        fig_ack = 1'b1;
        tick();
        check_eq("midrst_fig_req", 32'(fig_req), 32'h0);
        check_eq("midrst_grant",   32'(grant),   32'h0);
        check_eq("midrst_src_ack", 32'(src_ack), 32'h0);
        reset_n = 1'b1;
        fig_ack = 1'b0;
        tick();
        check_eq("midrst_next_grant", 32'(grant),   32'h1);
        check_eq("midrst_no_ack",     32'(src_ack), 32'h0);

        // Lone requester equal to last is re-served.
        fig_ack = 1'b1;
        tick();
        fig_ack = 1'b0;
        src_req = 4'b0001;
        tick();
        tick();
        check_eq("lone_grant", 32'(grant), 32'h1);
        check_eq("lone_fig_v", 32'(fig_v), 32'h60);
        check_eq("lone_fig_s", 32'(fig_s), 32'h50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
